// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the bit-serial subtractor and its sibling ripple adder.
// Holds the controller state encoding and the library-wide default operand width.
package serial_subtractor_pkg;

  // Default operand width shared across the arithmetic library.
  localparam int unsigned ARITH_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } sub_state_t;

  // Counter width for a serial unit of the given operand width (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes a - b - bin and the resulting borrow.
// Purely combinational.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  logic a_xor_b;

  always_comb begin
    a_xor_b = a ^ b;
    diff    = a_xor_b ^ bin;
    // Borrow when b exceeds a, or when a equals b and a borrow is already pending.
    borrow  = (~a & b) | (~a_xor_b & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: one bit of a - b per clock, LSB first.
// A start/done handshake wraps a three-state controller around a single full-subtractor cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             brw_q, brw_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic bit_diff;
  logic bit_borrow;
  logic accept;

  full_subtractor u_full_subtractor (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .bin    (brw_q),
    .diff   (bit_diff),
    .borrow (bit_borrow)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = start;
      end
      StRun: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d = {bit_diff, r_sh_q[WIDTH-1:1]};
        brw_d  = bit_borrow;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Publish the result including the bit processed on this edge.
          diff_d  = {bit_diff, r_sh_q[WIDTH-1:1]};
          bout_d  = bit_borrow;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        accept  = start;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      r_sh_d  = '0;
      brw_d   = 1'b0;
      cnt_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    diff = diff_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Caller must be at a negedge; returns at the negedge where done is high.
  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     output logic [3:0] d, output logic bo, output int nbusy);
    bit got;
    got = 1'b0;
    nbusy = 0;
    d = '0;
    bo = 1'b0;
    start4 = 1'b1;
    a4 = a;
    b4 = b;
    @(negedge clk);
    start4 = 1'b0;
    a4 = ~a;
    b4 = ~b;
    for (int i = 0; i < 20; i++) begin
      chk("busy_done_overlap4", 32'(busy4 & done4), 32'd0);
      if (done4) begin
        got = 1'b1;
        d = diff4;
        bo = bout4;
        break;
      end
      if (busy4) nbusy++;
      @(negedge clk);
    end
    chk("done_timeout4", 32'(got), 32'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] d, output logic bo, output int nbusy);
    bit got;
    got = 1'b0;
    nbusy = 0;
    d = '0;
    bo = 1'b0;
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a;
    b8 = ~b;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin
        got = 1'b1;
        d = diff8;
        bo = bout8;
        break;
      end
      if (busy8) nbusy++;
      @(negedge clk);
    end
    chk("done_timeout8", 32'(got), 32'd1);
  endtask

  initial begin
    logic [3:0] d4;
    logic [7:0] d8, ra, rb, ed;
    logic       bo;
    int         nb, ndone, c0;

    tbl[0] = '{a: 4'd9,  b: 4'd4,  d: 4'd5,  bo: 1'b0};
    tbl[1] = '{a: 4'd4,  b: 4'd9,  d: 4'hB,  bo: 1'b1};
    tbl[2] = '{a: 4'd0,  b: 4'd1,  d: 4'hF,  bo: 1'b1};
    tbl[3] = '{a: 4'd15, b: 4'd15, d: 4'd0,  bo: 1'b0};
    tbl[4] = '{a: 4'd8,  b: 4'd1,  d: 4'd7,  bo: 1'b0};
    tbl[5] = '{a: 4'd1,  b: 4'd8,  d: 4'd9,  bo: 1'b1};
    tbl[6] = '{a: 4'd0,  b: 4'd15, d: 4'd1,  bo: 1'b1};
    tbl[7] = '{a: 4'd12, b: 4'd3,  d: 4'd9,  bo: 1'b0};

    rst_n = 1'b0;
    start4 = 1'b0;
    a4 = '0;
    b4 = '0;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy4), 32'd0);
    chk("reset_done", 32'(done4), 32'd0);
    chk("reset_diff", 32'(diff4), 32'd0);
    chk("reset_bout", 32'(bout4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Odd entries pass through IDLE; even ones start straight from DONE.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) @(negedge clk);
      op4(tbl[i].a, tbl[i].b, d4, bo, nb);
      chk($sformatf("tbl%0d_diff", i), 32'(d4), 32'(tbl[i].d));
      chk($sformatf("tbl%0d_bout", i), 32'(bo), 32'(tbl[i].bo));
      chk($sformatf("tbl%0d_busy_cycles", i), 32'(nb), 32'd4);
    end

    // Start during RUN is ignored; previous result holds until completion.
    @(negedge clk);
    start4 = 1'b1;
    a4 = 4'd7;
    b4 = 4'd2;
    @(negedge clk);
    start4 = 1'b0;
    chk("hold_diff_in_run", 32'(diff4), 32'd9);
    chk("hold_bout_in_run", 32'(bout4), 32'd0);
    @(negedge clk);
    start4 = 1'b1;
    a4 = 4'd1;
    b4 = 4'd1;
    @(negedge clk);
    start4 = 1'b0;
    ndone = 0;
    d4 = '0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        ndone++;
        d4 = diff4;
      end
      @(negedge clk);
    end
    chk("ignore_start_ndone", 32'(ndone), 32'd1);
    chk("ignore_start_diff", 32'(d4), 32'd5);
    chk("hold_diff_in_idle", 32'(diff4), 32'd5);

    // Back-to-back: second start asserted in the DONE cycle.
    op4(4'd10, 4'd3, d4, bo, nb);
    chk("b2b_first_diff", 32'(d4), 32'd7);
    chk("b2b_first_bout", 32'(bo), 32'd0);
    c0 = cyc;
    op4(4'd3, 4'd10, d4, bo, nb);
    chk("b2b_second_diff", 32'(d4), 32'd9);
    chk("b2b_second_bout", 32'(bo), 32'd1);
    chk("b2b_done_spacing", 32'(cyc - c0), 32'd5);

    // Reset in the middle of RUN.
    @(negedge clk);
    start4 = 1'b1;
    a4 = 4'd12;
    b4 = 4'd5;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_done", 32'(done4), 32'd0);
    chk("midrst_diff", 32'(diff4), 32'd0);
    chk("midrst_bout", 32'(bout4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    op4(4'd6, 4'd6, d4, bo, nb);
    chk("after_rst_diff", 32'(d4), 32'd0);
    chk("after_rst_bout", 32'(bo), 32'd0);

    // WIDTH=8 sweep: corners first, then random operands.
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0: begin ra = 8'd0;   rb = 8'd0;   end
        1: begin ra = 8'd0;   rb = 8'd255; end
        2: begin ra = 8'd255; rb = 8'd0;   end
        3: begin ra = 8'd128; rb = 8'd1;   end
        4: begin ra = 8'd1;   rb = 8'd128; end
        default: begin
          ra = 8'($urandom_range(255));
          rb = 8'($urandom_range(255));
        end
      endcase
      ed = ra - rb;
      op8(ra, rb, d8, bo, nb);
      chk($sformatf("w8_diff a=%0d b=%0d", ra, rb), 32'(d8), 32'(ed));
      chk($sformatf("w8_bout a=%0d b=%0d", ra, rb), 32'(bo), 32'(ra < rb));
      if (i == 0) chk("w8_busy_cycles", 32'(nb), 32'd8);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
